// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - character-LCD write sequencer with power-up init ROM
// Purpose: waits out LCD power-up, plays a 4-command init ROM, then serves
//          user byte writes as SETUP / EN / HOLD / WAIT transfers.
// Ports:
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   i_start               begin power-up + init (honoured in IDLE only)
//   o_init_done           init ROM finished; sticky until reset
//   i_req, i_rs, i_data   user write request; accepted when o_ready=1
//   o_ready               a request can be accepted this cycle
//   o_LCD_DATA/EN/RS      LCD bus, RS/DATA constant across a transfer
//   o_LCD_RW              tied low (write-only use)
//   o_LCD_ON, o_LCD_BLON  power and backlight, high once started
module lcd_sequencer #(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_init_done,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic [7:0] o_LCD_DATA,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  output logic       o_LCD_ON,
  output logic       o_LCD_BLON
);

  localparam int unsigned MAX_AB  = (PWRUP_CYC > SETUP_CYC) ? PWRUP_CYC : SETUP_CYC;
  localparam int unsigned MAX_CD  = (EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC;
  localparam int unsigned MAX_EF  = (WAIT_CYC > CLR_WAIT_CYC) ? WAIT_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_CYC = (MAX_ABC > MAX_EF) ? MAX_ABC : MAX_EF;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_SETUP, S_EN, S_HOLD, S_WAIT, S_READY
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             en_q;
  logic             ready_q;
  logic             done_q;
  logic             pwr_q;

  logic             accept_d;
  logic             cnt_zero_d;
  logic [CNT_W-1:0] wait_ld_d;
  logic [1:0]       idx_d;

  function automatic logic [7:0] rom_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    rom_byte = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    rom_byte = 8'h0C;  // display on, cursor off
      2'd2:    rom_byte = 8'h01;  // clear display
      default: rom_byte = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  // ready_q is only ever high while in READY, so it alone qualifies accept.
  assign accept_d   = i_req & ready_q;
  assign cnt_zero_d = (cnt_q == '0);
  assign idx_d      = idx_q + 2'd1;
  // Clear (0x01) and home (0x02) commands need the long busy wait.
  assign wait_ld_d  = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLR_LD : WAIT_LD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pwr_q   <= 1'b0;
    end else begin
      // EN and the handshake flags trail the state by one cycle; this gives
      // RS/DATA one extra setup cycle and makes o_ready/o_init_done rise together.
      en_q    <= (state_q == S_EN);
      ready_q <= (state_q == S_READY) && !accept_d;
      if (state_q == S_READY) done_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_PWRUP;
            cnt_q   <= PWRUP_LD;
            pwr_q   <= 1'b1;
          end
        end
        S_PWRUP: begin
          if (cnt_zero_d) begin
            state_q <= S_SETUP;
            cnt_q   <= SETUP_LD;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            data_q  <= rom_byte(2'd0);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (cnt_zero_d) begin
            state_q <= S_EN;
            cnt_q   <= EN_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EN: begin
          if (cnt_zero_d) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero_d) begin
            state_q <= S_WAIT;
            cnt_q   <= wait_ld_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_zero_d) begin
            // done_q is still low while the init ROM is being played.
            if (!done_q && idx_q != 2'd3) begin
              state_q <= S_SETUP;
              cnt_q   <= SETUP_LD;
              idx_q   <= idx_d;
              rs_q    <= 1'b0;
              data_q  <= rom_byte(idx_d);
            end else begin
              state_q <= S_READY;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_READY: begin
          if (accept_d) begin
            state_q <= S_SETUP;
            cnt_q   <= SETUP_LD;
            rs_q    <= i_rs;
            data_q  <= i_data;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_init_done = done_q;
  assign o_ready     = ready_q;
  assign o_LCD_DATA  = data_q;
  assign o_LCD_EN    = en_q;
  assign o_LCD_RS    = rs_q;
  assign o_LCD_RW    = 1'b0;
  assign o_LCD_ON    = pwr_q;
  assign o_LCD_BLON  = pwr_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer
module tb_lcd_sequencer;
  localparam int PW = 20, SU = 2, ENC = 4, HO = 2, WT = 10, CW = 50;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, req = 1'b0, rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       init_done, ready, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] lcd_data;

  lcd_sequencer #(
    .PWRUP_CYC(PW), .SETUP_CYC(SU), .EN_CYC(ENC),
    .HOLD_CYC(HO), .WAIT_CYC(WT), .CLR_WAIT_CYC(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_init_done(init_done),
    .i_req(req), .i_rs(rs), .i_data(data), .o_ready(ready),
    .o_LCD_DATA(lcd_data), .o_LCD_EN(lcd_en), .o_LCD_RS(lcd_rs),
    .o_LCD_RW(lcd_rw), .o_LCD_ON(lcd_on), .o_LCD_BLON(lcd_blon)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int         start;
    int         width;
    logic       rs;
    logic [7:0] data;
    logic       stable;
  } pulse_t;

  pulse_t pq[$];
  pulse_t cur;
  logic   in_p = 1'b0;
  int     rw_bad = 0;

  // Bus monitor: collects each complete EN pulse (rise cycle, width, payload)
  // and whether RS/DATA stayed put from one cycle before rise to the fall.
  initial begin
    logic       prv_rs;
    logic [7:0] prv_data;
    prv_rs = 1'b0;
    prv_data = 8'h00;
    forever begin
      @(negedge clk);
      if (lcd_rw !== 1'b0) rw_bad++;
      if (!rst_n) begin
        in_p = 1'b0;
      end else if (lcd_en) begin
        if (!in_p) begin
          in_p = 1'b1;
          cur.start = cyc;
          cur.width = 1;
          cur.rs = lcd_rs;
          cur.data = lcd_data;
          cur.stable = (prv_rs === lcd_rs) && (prv_data === lcd_data);
        end else begin
          cur.width++;
          if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
        end
      end else if (in_p) begin
        in_p = 1'b0;
        if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
        pq.push_back(cur);
      end
      prv_rs = lcd_rs;
      prv_data = lcd_data;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference timing from the datasheet rules: long wait for clear/home commands.
  function automatic int model_wait(input logic r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02)) ? CW : WT;
  endfunction

  function automatic int model_period(input logic r, input logic [7:0] d);
    return SU + ENC + HO + model_wait(r, d) + 1;
  endfunction

  task automatic chk_pulse(input string nm, input int acc, input logic r, input logic [7:0] d);
    pulse_t p;
    chk({nm, " npulses"}, pq.size(), 1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      chk({nm, " en_rise"}, p.start - acc, SU + 1);
      chk({nm, " en_width"}, p.width, ENC);
      chk({nm, " rs"}, p.rs, r);
      chk({nm, " data"}, p.data, d);
      chk({nm, " stable"}, p.stable, 1);
    end
  endtask

  task automatic do_req(input string nm, input logic r, input logic [7:0] d, input int exp_per);
    int acc, t;
    pq.delete();
    @(negedge clk);
    req = 1'b1; rs = r; data = d;
    t = 0;
    while (!ready && t < 300) begin @(negedge clk); t++; end
    if (!ready) begin
      chk({nm, " accept_timeout"}, 0, 1);
      req = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(negedge clk);
    req = 1'b0; rs = ~r; data = ~d;
    chk({nm, " ready_drop"}, ready, 0);
    t = 0;
    while (!ready && t < 300) begin @(negedge clk); t++; end
    chk({nm, " period"}, cyc - acc, exp_per);
    chk_pulse(nm, acc, r, d);
  endtask

  task automatic do_init(input string nm);
    int s0, t, st;
    logic [7:0] rom[4];
    pulse_t p;
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    pq.delete();
    @(negedge clk);
    start = 1'b1;
    s0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " lcd_on"}, {lcd_on, lcd_blon}, 2'b11);
    t = 0;
    while (!init_done && t < 1000) begin @(negedge clk); t++; end
    chk({nm, " npulses"}, pq.size(), 4);
    st = s0 + PW + SU + 1;
    for (int i = 0; i < 4; i++) begin
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk($sformatf("%s p%0d rise", nm, i), p.start - s0, st - s0);
        chk($sformatf("%s p%0d width", nm, i), p.width, ENC);
        chk($sformatf("%s p%0d rs", nm, i), p.rs, 0);
        chk($sformatf("%s p%0d data", nm, i), p.data, rom[i]);
        chk($sformatf("%s p%0d stable", nm, i), p.stable, 1);
      end
      if (i < 3) st += ENC + HO + model_wait(1'b0, rom[i]) + SU;
    end
    chk({nm, " done_time"}, cyc - s0, st + ENC + HO + model_wait(1'b0, rom[3]) - s0);
    chk({nm, " ready_with_done"}, ready, 1);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    int         per;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   acc, t;
    logic r;
    logic [7:0] d;

    vecs[0] = '{1'b1, 8'h41, 19};
    vecs[1] = '{1'b0, 8'h01, 59};
    vecs[2] = '{1'b1, 8'h01, 19};
    vecs[3] = '{1'b0, 8'h02, 59};
    vecs[4] = '{1'b0, 8'h38, 19};
    vecs[5] = '{1'b1, 8'h02, 19};
    vecs[6] = '{1'b0, 8'h03, 19};
    vecs[7] = '{1'b0, 8'h00, 19};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {lcd_en, lcd_rs, lcd_data, ready, init_done, lcd_on, lcd_blon, lcd_rw}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_waits", {lcd_on, ready, init_done}, 0);
    chk("idle_no_en", pq.size(), 0);

    // Start with a request held: init only, held request taken on first READY cycle
    req = 1'b1; rs = 1'b1; data = 8'h55;
    do_init("init1");
    acc = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    chk("held ready_drop", ready, 0);
    t = 0;
    while (!ready && t < 300) begin @(negedge clk); t++; end
    chk("held period", cyc - acc, 19);
    chk_pulse("held", acc, 1'b1, 8'h55);

    // i_start in READY is ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("start_in_ready pulses", pq.size(), 0);
    chk("start_in_ready state", {ready, init_done}, 2'b11);

    // Directed vectors
    for (int i = 0; i < 8; i++)
      do_req($sformatf("vec%0d", i), vecs[i].r, vecs[i].d, vecs[i].per);

    // Randomized requests against the reference model
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = 8'h01;
        1: d = 8'h02;
        default: d = 8'($urandom);
      endcase
      do_req($sformatf("rnd%0d", i), r, d, model_period(r, d));
    end

    // Reset during the EN phase of a user transfer
    @(negedge clk);
    req = 1'b1; rs = 1'b1; data = 8'hA5;
    t = 0;
    while (!ready && t < 300) begin @(negedge clk); t++; end
    @(negedge clk);
    req = 1'b0;
    t = 0;
    while (!lcd_en && t < 20) begin @(negedge clk); t++; end
    chk("midrst en_seen", lcd_en, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst en_low", lcd_en, 0);
    chk("midrst outputs", {lcd_en, lcd_rs, lcd_data, ready, init_done, lcd_on, lcd_blon, lcd_rw}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pq.delete();
    repeat (10) @(negedge clk);
    chk("midrst idle", {lcd_on, ready, init_done}, 0);
    chk("midrst no_en", pq.size(), 0);
    do_init("init2");
    do_req("post_rst", 1'b1, 8'h41, 19);

    chk("rw_const", rw_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
